// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Presents each good byte on data with a one-cycle valid strobe and reports a low
// stop bit as a one-cycle frame_err strobe.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 2812
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF   = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       sh;
    logic [7:0]       sh_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt;
    logic             frame_err_nxt;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath and strobe decode
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        sh_nxt        = sh;
        data_nxt      = data;
        valid_nxt     = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end

            START: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_HALF) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                    end else begin
                        // line went back high before mid-bit: treat as a glitch
                        state_nxt = IDLE;
                    end
                end
            end

            DATA: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_FULL) begin
                    sh_nxt  = {rx_s, sh[7:1]};
                    cnt_nxt = '0;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end

            STOP: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_FULL) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    if (rx_s) begin
                        data_nxt  = sh;
                        valid_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output registers; busy tracks the registered state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            sh        <= sh_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            frame_err <= frame_err_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit, scoreboard driven.
module tb_uart_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned H   = CPB / 2;
    // rx drop -> strobe: 2 sync flops + IDLE detect edge, then H + 9N
    localparam int unsigned LAT = 3 + H + 9 * CPB;

    typedef struct {
        bit          err;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    exp_t        sb[$];
    int unsigned cyc           = 0;
    int unsigned n_checks      = 0;
    int unsigned n_pass        = 0;
    int unsigned strobe_total  = 0;
    int unsigned busy_hi_total = 0;
    logic [7:0]  last_good     = 8'h00;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // Single comparison point for every check in the bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_hi_total++;
        if (valid || frame_err) begin
            strobe_total++;
            check("both_strobes", 32'(valid && frame_err), 32'd0);
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("strobe_kind", 32'(frame_err), 32'(e.err));
                check("strobe_data", 32'(data), 32'(e.data));
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        wait_cycles(CPB);
    endtask

    // Sends one frame; expectation is pushed at the moment the start bit is driven
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit push);
        exp_t e;
        if (push) begin
            e.err  = !stop_ok;
            e.data = stop_ok ? b : last_good;
            e.cyc  = cyc + LAT;
            sb.push_back(e);
            if (stop_ok) last_good = b;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s0;
        int unsigned b0;
        logic [7:0]  c3;

        // 1. reset values (asynchronous) and quiet idle line
        reset = 1'b0;
        rx    = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        wait_cycles(3);
        reset = 1'b0;
        s0 = strobe_total;
        wait_cycles(100);
        check("idle_no_strobe", strobe_total - s0, 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // 2. single byte
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_cycles(20);
        check("a5_drained", 32'(sb.size()), 32'd0);
        check("a5_data_hold", 32'(data), 32'hA5);

        // 3. back-to-back frames, zero idle gap
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1);
        wait_cycles(20);
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // 4. framing error keeps the previous byte
        send_frame(8'h3C, 1'b0, 1'b1);
        rx = 1'b1;
        wait_cycles(100);
        check("ferr_drained", 32'(sb.size()), 32'd0);
        check("ferr_data_hold", 32'(data), 32'h55);
        check("ferr_busy_idle", 32'(busy), 32'd0);

        // 5. glitch rejection, then a good frame
        b0 = busy_hi_total;
        s0 = strobe_total;
        rx = 1'b0;
        wait_cycles(5);
        rx = 1'b1;
        wait_cycles(40);
        check("glitch_busy_cycles", busy_hi_total - b0, 32'(H));
        check("glitch_no_strobe", strobe_total - s0, 32'd0);
        send_frame(8'h81, 1'b1, 1'b1);
        wait_cycles(20);
        check("81_drained", 32'(sb.size()), 32'd0);

        // 6. reset during data bit 4 abandons the frame
        c3 = 8'hC3;
        s0 = strobe_total;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(c3[i]);
        rx = c3[4];
        wait_cycles(H);
        reset = 1'b1;
        #1;
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        last_good = 8'h00;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(50);
        check("midrst_no_strobe", strobe_total - s0, 32'd0);
        check("midrst_data_after", 32'(data), 32'h00);
        send_frame(8'h7E, 1'b1, 1'b1);
        wait_cycles(20);
        check("7e_data_hold", 32'(data), 32'h7E);
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
